// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
package fetch_pkg;

    // Fetch control states: FETCH issues requests, FLUSH drops one cycle after a redirect
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    // Every instruction occupies one 4-byte word
    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-around pointers, separate occupancy counter and a
// synchronous clear that takes priority over push and pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    // Guard against overflow/underflow even if the producer misbehaves
    assign push_ok = push_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i  && (count_q != '0);

    // Pointer and occupancy update; clear wins over everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage write; contents need no reset because the counter qualifies them
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential reads to a one-cycle-latency
// memory, buffers {insn, pc} pairs and hands them to a valid/ready consumer.
// A redirect flushes the queue and kills the in-flight response.
module fetch_queue import fetch_pkg::*; #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [AWIDTH-1:0]          mem_addr_o,
    output logic                       mem_read_en_o,
    input  logic [DWIDTH-1:0]          mem_data_i,
    input  logic                       redirect_i,
    input  logic [AWIDTH-1:0]          redirect_pc_i,
    output logic                       insn_valid_o,
    output logic [DWIDTH-1:0]          insn_o,
    output logic [AWIDTH-1:0]          pc_o,
    input  logic                       insn_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam int FW = DWIDTH + AWIDTH;

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] fpc_q, fpc_d;
    logic [AWIDTH-1:0] req_pc_q;
    logic              inflight_q;
    logic              req, push, pop, head_valid;
    logic [FW-1:0]     head;
    logic [CW-1:0]     count;
    logic [OW-1:0]     occ_sum, cap_sum;

    assign head_valid = (count != '0);
    assign pop        = head_valid && insn_ready_i;
    // A response is only captured if its request survived; redirect kills it
    assign push       = inflight_q && !redirect_i && (state_q == FETCH);

    // Room check: queued + in-flight must fit, with this cycle's pop freeing a slot
    assign occ_sum = OW'(count) + OW'(inflight_q);
    assign cap_sum = OW'(DEPTH) + OW'(pop);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next-state: redirect always lands in FLUSH, FLUSH lasts one cycle
    always_comb begin
        state_d = state_q;
        if (redirect_i)              state_d = FLUSH;
        else if (state_q == FLUSH)   state_d = FETCH;
    end

    // Output: issue a read only in FETCH, never under redirect or reset
    always_comb begin
        req = 1'b0;
        if (!rst && !redirect_i && (state_q == FETCH) && (occ_sum < cap_sum))
            req = 1'b1;
    end

    // Next fetch PC: redirect target, or advance past the word just requested
    always_comb begin
        fpc_d = fpc_q;
        if (redirect_i) fpc_d = redirect_pc_i;
        else if (req)   fpc_d = fpc_q + AWIDTH'(INSN_BYTES);
    end

    // Fetch PC, in-flight flag and the PC of the outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q      <= BASEADDR;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= req;
            if (req) req_pc_q <= fpc_q;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (redirect_i),
        .push_i  (push),
        .wdata_i ({mem_data_i, req_pc_q}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    assign mem_addr_o    = fpc_q;
    assign mem_read_en_o = req;
    assign count_o       = count;
    // Head fields read as zero whenever nothing valid is queued (including reset)
    assign insn_valid_o  = head_valid;
    assign insn_o        = head_valid ? head[FW-1:AWIDTH] : '0;
    assign pc_o          = head_valid ? head[AWIDTH-1:0]  : '0;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 32, instruction/data width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-004 SHALL have parameter BASEADDR, default 32'h0100_0000, fetch PC after reset.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port mem_addr_o  output  AWIDTH  read address to memory.
REQ-008 SHALL have port mem_read_en_o  output  1  read request; data returns exactly one cycle later.
REQ-009 SHALL have port mem_data_i  input  DWIDTH  read data, valid the cycle after a request.
REQ-010 SHALL have port redirect_i  input  1  flush queue and restart fetch.
REQ-011 SHALL have port redirect_pc_i  input  AWIDTH  new fetch PC, sampled when redirect_i=1.
REQ-012 SHALL have port insn_valid_o  output  1  queue head holds a valid instruction.
REQ-013 SHALL have port insn_o  output  DWIDTH  head instruction.
REQ-014 SHALL have port pc_o  output  AWIDTH  PC of head instruction.
REQ-015 SHALL have port insn_ready_i  input  1  consumer accepts head; pop when valid and ready.
REQ-016 SHALL have port count_o  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-017 SHALL hold fetch PC register fpc; mem_addr_o = fpc combinationally.
REQ-018 SHALL assert mem_read_en_o in state FETCH when count + inflight + 0 < DEPTH, counting the head pop of the same cycle as freeing a slot; inflight is 1 if a request was issued last cycle and not killed.
REQ-019 SHALL increment fpc by 4 (modulo 2^AWIDTH, wrap to 0 with no error) each cycle mem_read_en_o=1.
REQ-020 SHALL push {mem_data_i, request PC} into the queue the cycle after an unkilled request; push and pop in the same cycle leave count unchanged.
REQ-021 SHALL present queue head on insn_o/pc_o with insn_valid_o = (count != 0); outputs stable while valid and not ready.
REQ-022 SHALL never push when full nor pop when empty; REQ-018 makes overflow impossible and the bench shall assert it.
REQ-023 SHALL implement states FETCH and FLUSH; reset enters FETCH.
REQ-024 SHALL, on redirect_i=1 in any state: set fpc=redirect_pc_i, clear queue (count=0), kill any in-flight response, deassert mem_read_en_o that cycle, go to FLUSH.
REQ-025 SHALL in FLUSH drop mem_data_i, issue no request, and return to FETCH next cycle unless redirect_i=1 again.
REQ-026 SHALL give redirect priority over push and pop in the same cycle; a pop coinciding with redirect is still a completed handshake for the consumer.
REQ-027 SHALL force insn_valid_o=0 in the cycle after redirect; first post-redirect instruction appears no earlier than 3 cycles after redirect.
REQ-028 SHALL have steady-state latency of 2 cycles from request to insn_valid_o at an empty queue and throughput of one instruction per cycle with insn_ready_i held high.
REQ-029 SHALL use wrap-around read/write pointers of $clog2(DEPTH) bits with separate occupancy counter.

Reset
REQ-030 SHALL on rst=1 asynchronously set fpc=BASEADDR, count_o=0, pointers=0, inflight=0, state=FETCH.
REQ-031 SHALL hold mem_read_en_o=0, insn_valid_o=0, insn_o=0, pc_o=0 while rst=1.
REQ-032 SHALL discard any response arriving in the first cycle after reset deassertion.
REQ-033 SHALL abandon any in-progress fill when rst asserts mid-operation; no stale entry may appear afterwards.

Structure
REQ-034 SHALL place fetch state enum (FETCH, FLUSH) and constant INSN_BYTES=4 in shared package fetch_pkg.
REQ-035 SHALL instantiate one sub-module, sync_fifo (parametrised WIDTH, DEPTH), for queue storage; replaces the prior standalone fetch block in the top level.

Verification
REQ-036 Reset release, insn_ready_i=1, memory returns addr as data -> first insn_valid_o cycle 2, pc_o=0x0100_0000, then +4 every cycle.
REQ-037 DEPTH=4, insn_ready_i=0 -> exactly 4 requests, count_o=4, mem_read_en_o stays 0; raise ready -> pops 0x0100_0000..0x0100_000C in order.
REQ-038 Redirect to 0x0000_2000 with queue holding 3 entries and one in flight -> count_o=0 next cycle, killed data never seen, next head pc_o=0x0000_2000.
REQ-039 Redirect on consecutive cycles (0x40 then 0x80) -> only 0x80 stream appears.
REQ-040 redirect_pc_i=0xFFFF_FFFC -> pc_o sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-041 rst asserted with count_o=2 mid-fill -> outputs zero immediately; after release stream restarts at BASEADDR.
